// File: rtl/minimac_syncfifo_if.sv
// Handshake bundle for minimac_syncfifo; master = FIFO user, slave = FIFO.
// WrErr_out/RdErr_out exist only when MINIMAC_SYNCFIFO_ERRFLAGS_EN is defined.
interface minimac_syncfifo_if #(
  parameter int unsigned DATA_WIDTH    = 9,
  parameter int unsigned ADDRESS_WIDTH = 4
);
  logic                   Clear_in;
  logic [DATA_WIDTH-1:0]  Data_in;
  logic                   WriteEn_in;
  logic                   Full_out;
  logic                   AlmostFull_out;
  logic [DATA_WIDTH-1:0]  Data_out;
  logic                   ReadEn_in;
  logic                   Empty_out;
  logic                   AlmostEmpty_out;
  logic [ADDRESS_WIDTH:0] Level_out;
`ifdef MINIMAC_SYNCFIFO_ERRFLAGS_EN
  logic                   WrErr_out;
  logic                   RdErr_out;

  modport master (
    output Clear_in, Data_in, WriteEn_in, ReadEn_in,
    input  Full_out, AlmostFull_out, Data_out, Empty_out, AlmostEmpty_out, Level_out,
           WrErr_out, RdErr_out
  );
  modport slave (
    input  Clear_in, Data_in, WriteEn_in, ReadEn_in,
    output Full_out, AlmostFull_out, Data_out, Empty_out, AlmostEmpty_out, Level_out,
           WrErr_out, RdErr_out
  );
`else
  modport master (
    output Clear_in, Data_in, WriteEn_in, ReadEn_in,
    input  Full_out, AlmostFull_out, Data_out, Empty_out, AlmostEmpty_out, Level_out
  );
  modport slave (
    input  Clear_in, Data_in, WriteEn_in, ReadEn_in,
    output Full_out, AlmostFull_out, Data_out, Empty_out, AlmostEmpty_out, Level_out
  );
`endif
endinterface

// File: rtl/minimac_syncfifo.sv
// Single-clock parametrised FIFO with FWFT/standard read, level and almost flags.
// Define MINIMAC_SYNCFIFO_ERRFLAGS_EN to add sticky overflow/underflow flags.
module minimac_syncfifo #(
  parameter int unsigned DATA_WIDTH    = 9,
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned FWFT          = 1,
  parameter int unsigned AF_THRESH     = 12,
  parameter int unsigned AE_THRESH     = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  minimac_syncfifo_if.slave  fifo
);
  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

  typedef logic [ADDRESS_WIDTH-1:0] ptr_t;
  typedef logic [ADDRESS_WIDTH:0]   lvl_t;
  typedef logic [DATA_WIDTH-1:0]    word_t;

  localparam lvl_t DEPTH_LVL = lvl_t'(DEPTH);
  localparam lvl_t AF_LVL    = lvl_t'(AF_THRESH);
  localparam lvl_t AE_LVL    = lvl_t'(AE_THRESH);

  word_t mem [DEPTH];
  ptr_t  wr_ptr;
  ptr_t  rd_ptr;
  ptr_t  rd_ptr_next;
  lvl_t  level;
  lvl_t  level_next;
  logic  full;
  logic  empty;
  logic  almost_full;
  logic  almost_empty;
  logic  wr_acc;
  logic  rd_acc;
  word_t head_next;
  word_t data_q;

  always_comb begin
    wr_acc      = fifo.WriteEn_in && !full;
    rd_acc      = fifo.ReadEn_in && !empty;
    rd_ptr_next = rd_acc ? rd_ptr + ptr_t'(1) : rd_ptr;
    level_next  = level;
    case ({wr_acc, rd_acc})
      2'b10:   level_next = level + lvl_t'(1);
      2'b01:   level_next = level - lvl_t'(1);
      default: level_next = level;
    endcase
    // When the new head is the word being written this edge, it is not in mem yet.
    if (wr_acc && (wr_ptr == rd_ptr_next)) begin
      head_next = fifo.Data_in;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= fifo.Data_in;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || fifo.Clear_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      data_q       <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      rd_ptr       <= rd_ptr_next;
      level        <= level_next;
      full         <= (level_next == DEPTH_LVL);
      empty        <= (level_next == '0);
      almost_full  <= (level_next >= AF_LVL);
      almost_empty <= (level_next <= AE_LVL);
      if (FWFT != 0) begin
        if (level_next != '0) begin
          data_q <= head_next;
        end
      end else if (rd_acc) begin
        data_q <= mem[rd_ptr];
      end
    end
  end

  assign fifo.Full_out        = full;
  assign fifo.AlmostFull_out  = almost_full;
  assign fifo.Empty_out       = empty;
  assign fifo.AlmostEmpty_out = almost_empty;
  assign fifo.Level_out       = level;
  assign fifo.Data_out        = data_q;

`ifdef MINIMAC_SYNCFIFO_ERRFLAGS_EN
  logic wr_err;
  logic rd_err;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || fifo.Clear_in) begin
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      wr_err <= wr_err | (fifo.WriteEn_in && full);
      rd_err <= rd_err | (fifo.ReadEn_in && empty);
    end
  end

  assign fifo.WrErr_out = wr_err;
  assign fifo.RdErr_out = rd_err;
`endif

endmodule

// File: tb/tb_minimac_syncfifo.sv
// Directed bench: FWFT instance (dut_a) and standard-read instance (dut_b).
module tb_minimac_syncfifo;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  minimac_syncfifo_if #(.DATA_WIDTH(9), .ADDRESS_WIDTH(4)) fa ();
  minimac_syncfifo_if #(.DATA_WIDTH(9), .ADDRESS_WIDTH(4)) fb ();

  minimac_syncfifo #(
    .DATA_WIDTH(9), .ADDRESS_WIDTH(4), .FWFT(1), .AF_THRESH(12), .AE_THRESH(2)
  ) dut_a (.sys_clk(clk), .sys_rst(rst), .fifo(fa.slave));

  minimac_syncfifo #(
    .DATA_WIDTH(9), .ADDRESS_WIDTH(4), .FWFT(0), .AF_THRESH(12), .AE_THRESH(2)
  ) dut_b (.sys_clk(clk), .sys_rst(rst), .fifo(fb.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    fa.Clear_in = 1'b0; fa.WriteEn_in = 1'b0; fa.ReadEn_in = 1'b0; fa.Data_in = '0;
  endtask

  task automatic idle_b();
    fb.Clear_in = 1'b0; fb.WriteEn_in = 1'b0; fb.ReadEn_in = 1'b0; fb.Data_in = '0;
  endtask

  initial begin
    idle_a();
    idle_b();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_level", fa.Level_out, 0);
    check("rst_empty", fa.Empty_out, 1);
    check("rst_full", fa.Full_out, 0);
    check("rst_ae", fa.AlmostEmpty_out, 1);
    check("rst_af", fa.AlmostFull_out, 0);
    check("rst_data", fa.Data_out, 0);
`ifdef MINIMAC_SYNCFIFO_ERRFLAGS_EN
    check("rst_wrerr", fa.WrErr_out, 0);
    check("rst_rderr", fa.RdErr_out, 0);
`endif

    // 1: single write falls through
    fa.WriteEn_in = 1'b1; fa.Data_in = 9'h101;
    tick();
    idle_a();
    check("t1_empty", fa.Empty_out, 0);
    check("t1_data", fa.Data_out, 9'h101);
    check("t1_level", fa.Level_out, 1);
    check("t1_ae", fa.AlmostEmpty_out, 1);
    fa.Clear_in = 1'b1;
    tick();
    idle_a();
    check("t1_clr_level", fa.Level_out, 0);

    // 2: fill to full
    for (int i = 0; i < 16; i++) begin
      fa.WriteEn_in = 1'b1; fa.Data_in = 9'(i);
      tick();
      check("t2_level", fa.Level_out, i + 1);
      check("t2_full", fa.Full_out, (i + 1 == 16) ? 1 : 0);
      check("t2_af", fa.AlmostFull_out, (i + 1 >= 12) ? 1 : 0);
      check("t2_ae", fa.AlmostEmpty_out, (i + 1 <= 2) ? 1 : 0);
      check("t2_data", fa.Data_out, 0);
    end
    fa.Data_in = 9'h155;
    tick();
    idle_a();
    check("t2_ovf_level", fa.Level_out, 16);
    check("t2_ovf_full", fa.Full_out, 1);
`ifdef MINIMAC_SYNCFIFO_ERRFLAGS_EN
    check("t2_wrerr", fa.WrErr_out, 1);
`endif

    // 3: read+write while full drops the write
    fa.WriteEn_in = 1'b1; fa.ReadEn_in = 1'b1; fa.Data_in = 9'h1FF;
    tick();
    idle_a();
    check("t3_data", fa.Data_out, 9'h001);
    check("t3_level", fa.Level_out, 15);
    check("t3_full", fa.Full_out, 0);
    for (int k = 1; k < 16; k++) begin
      check("t3_drain_data", fa.Data_out, k);
      check("t3_drain_level", fa.Level_out, 16 - k);
      check("t3_drain_ae", fa.AlmostEmpty_out, (16 - k <= 2) ? 1 : 0);
      fa.ReadEn_in = 1'b1;
      tick();
    end
    idle_a();
    check("t3_empty", fa.Empty_out, 1);
    check("t3_level0", fa.Level_out, 0);
`ifdef MINIMAC_SYNCFIFO_ERRFLAGS_EN
    check("t3_rderr", fa.RdErr_out, 0);
`endif

    // 4: steady streaming at level 5 across pointer wrap
    for (int i = 0; i < 5; i++) begin
      fa.WriteEn_in = 1'b1; fa.Data_in = 9'(32 + i);
      tick();
    end
    idle_a();
    check("t4_level5", fa.Level_out, 5);
    check("t4_head", fa.Data_out, 9'h020);
    for (int k = 0; k < 40; k++) begin
      fa.WriteEn_in = 1'b1; fa.ReadEn_in = 1'b1; fa.Data_in = 9'(37 + k);
      tick();
      check("t4_data", fa.Data_out, 33 + k);
      check("t4_level", fa.Level_out, 5);
    end
    idle_a();

    // 6: clear wins over simultaneous read+write
    for (int i = 0; i < 2; i++) begin
      fa.WriteEn_in = 1'b1; fa.Data_in = 9'(100 + i);
      tick();
    end
    idle_a();
    check("t6_level7", fa.Level_out, 7);
    fa.Clear_in = 1'b1; fa.WriteEn_in = 1'b1; fa.ReadEn_in = 1'b1; fa.Data_in = 9'h0CC;
    tick();
    idle_a();
    check("t6_level", fa.Level_out, 0);
    check("t6_empty", fa.Empty_out, 1);
    check("t6_full", fa.Full_out, 0);
    check("t6_ae", fa.AlmostEmpty_out, 1);
    check("t6_data", fa.Data_out, 0);
`ifdef MINIMAC_SYNCFIFO_ERRFLAGS_EN
    check("t6_wrerr", fa.WrErr_out, 0);
    check("t6_rderr", fa.RdErr_out, 0);
`endif

    // 5: standard registered read
    fb.WriteEn_in = 1'b1; fb.Data_in = 9'h0AA;
    tick();
    check("t5_empty_after_wr", fb.Empty_out, 0);
    fb.Data_in = 9'h0BB;
    tick();
    idle_b();
    check("t5_level2", fb.Level_out, 2);
    check("t5_data_hold", fb.Data_out, 0);
    fb.ReadEn_in = 1'b1;
    tick();
    check("t5_rd1", fb.Data_out, 9'h0AA);
    tick();
    check("t5_rd2", fb.Data_out, 9'h0BB);
    check("t5_empty", fb.Empty_out, 1);
    tick();
    idle_b();
    check("t5_rd3_hold", fb.Data_out, 9'h0BB);
    check("t5_level0", fb.Level_out, 0);
`ifdef MINIMAC_SYNCFIFO_ERRFLAGS_EN
    check("t5_rderr", fb.RdErr_out, 1);
`endif
    tick();
    check("t5_idle_hold", fb.Data_out, 9'h0BB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
